// File: rtl/poly_nco_pkg.sv
// Shared constants and helpers for the polyphonic NCO.
// Build option: POLY_NCO_PHASE_RST_EN (note-on phase reset) is handled in nco_voice_step / poly_nco.
package poly_nco_pkg;

   localparam int DEF_D_W      = 16;
   localparam int DEF_ADDR_W   = 8;
   localparam int DEF_N_VOICES = 4;

   // Voice index width; a single voice still needs one bit to carry an index.
   function automatic int vidx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/nco_voice_step.sv
// Combinational next-state of one voice: divider counter, buffered divider, address, step flag.
// Build option POLY_NCO_PHASE_RST_EN adds the gate_q port and note-on phase reset.
module nco_voice_step
   import poly_nco_pkg::*;
#(
   parameter int D_W    = DEF_D_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              gate,
`ifdef POLY_NCO_PHASE_RST_EN
   input  logic              gate_q,
`endif
   input  logic [D_W-1:0]    div,
   input  logic [D_W-1:0]    ctr,
   input  logic [D_W-1:0]    bdiv,
   input  logic [ADDR_W-1:0] addr,
   output logic [D_W-1:0]    ctr_nxt,
   output logic [D_W-1:0]    bdiv_nxt,
   output logic [ADDR_W-1:0] addr_nxt,
   output logic              step
);

   always_comb begin
      ctr_nxt  = ctr;
      bdiv_nxt = bdiv;
      addr_nxt = addr;
      step     = 1'b0;
`ifdef POLY_NCO_PHASE_RST_EN
      if (gate && !gate_q) begin
         ctr_nxt  = '0;
         bdiv_nxt = div;
         addr_nxt = '0;
      end else
`endif
      // The divider is only sampled while idle or at a wrap, so a running period never changes pitch.
      if (!gate) begin
         ctr_nxt  = '0;
         bdiv_nxt = div;
      end else if (ctr >= bdiv) begin
         ctr_nxt  = '0;
         bdiv_nxt = div;
         addr_nxt = addr + 1'b1;
         step     = 1'b1;
      end else begin
         ctr_nxt = ctr + 1'b1;
      end
   end

endmodule

// File: rtl/poly_nco.sv
// Polyphonic wavetable-address NCO: voices are serviced one per clock by a shared step unit.
// Build option POLY_NCO_PHASE_RST_EN restarts a voice at address 0 on each note-on.
module poly_nco
   import poly_nco_pkg::*;
#(
   parameter int  D_W      = DEF_D_W,
   parameter int  ADDR_W   = DEF_ADDR_W,
   parameter int  N_VOICES = DEF_N_VOICES,
   localparam int VIDX_W   = vidx_w(N_VOICES)
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst,
   input  logic [N_VOICES-1:0]        voice_gate,
   input  logic [N_VOICES*D_W-1:0]    nco_div,
   output logic [N_VOICES*ADDR_W-1:0] voice_addr,
   output logic                       step_valid,
   output logic [VIDX_W-1:0]          step_voice,
   output logic [ADDR_W-1:0]          step_addr
);

   logic [VIDX_W-1:0] slot;
   logic [D_W-1:0]    ctr  [N_VOICES];
   logic [D_W-1:0]    bdiv [N_VOICES];
   logic [ADDR_W-1:0] addr [N_VOICES];
   logic [D_W-1:0]    div_arr [N_VOICES];
`ifdef POLY_NCO_PHASE_RST_EN
   logic [N_VOICES-1:0] gate_q;
`endif

   logic [D_W-1:0]    ctr_nxt;
   logic [D_W-1:0]    bdiv_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic              step;

   for (genvar v = 0; v < N_VOICES; v++) begin : g_unpack
      assign div_arr[v]                       = nco_div[v*D_W +: D_W];
      assign voice_addr[v*ADDR_W +: ADDR_W]   = addr[v];
   end

   nco_voice_step #(
      .D_W    (D_W),
      .ADDR_W (ADDR_W)
   ) u_step (
      .gate     (voice_gate[slot]),
`ifdef POLY_NCO_PHASE_RST_EN
      .gate_q   (gate_q[slot]),
`endif
      .div      (div_arr[slot]),
      .ctr      (ctr[slot]),
      .bdiv     (bdiv[slot]),
      .addr     (addr[slot]),
      .ctr_nxt  (ctr_nxt),
      .bdiv_nxt (bdiv_nxt),
      .addr_nxt (addr_nxt),
      .step     (step)
   );

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         slot       <= '0;
         step_valid <= 1'b0;
         step_voice <= '0;
         step_addr  <= '0;
         for (int v = 0; v < N_VOICES; v++) begin
            ctr[v]  <= '0;
            bdiv[v] <= '0;
            addr[v] <= '0;
         end
`ifdef POLY_NCO_PHASE_RST_EN
         gate_q <= '0;
`endif
      end else begin
         slot       <= (slot == VIDX_W'(N_VOICES - 1)) ? '0 : slot + 1'b1;
         ctr[slot]  <= ctr_nxt;
         bdiv[slot] <= bdiv_nxt;
         addr[slot] <= addr_nxt;
         step_valid <= step;
         // Index and address are held between events so a consumer can read them late.
         if (step) begin
            step_voice <= slot;
            step_addr  <= addr_nxt;
         end
`ifdef POLY_NCO_PHASE_RST_EN
         gate_q[slot] <= voice_gate[slot];
`endif
      end
   end

endmodule

// File: tb/tb_poly_nco.sv
// Self-checking bench for poly_nco: vector table, directed corner sequences and a random run
// checked every cycle against a visits-remaining reference model.
module tb_poly_nco;

   localparam int D_W = 16;
   localparam int ADDR_W = 8;
   localparam int N = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [N-1:0]        gate = '0;
   logic [N*D_W-1:0]    div = '0;
   logic [N*ADDR_W-1:0] vaddr;
   logic                sv;
   logic [1:0]          svoice;
   logic [ADDR_W-1:0]   saddr;

   poly_nco #(.D_W(D_W), .ADDR_W(ADDR_W), .N_VOICES(N)) dut (
      .sys_clk    (clk),
      .sys_rst    (rst),
      .voice_gate (gate),
      .nco_div    (div),
      .voice_addr (vaddr),
      .step_valid (sv),
      .step_voice (svoice),
      .step_addr  (saddr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: each voice counts down the slot visits left before its next address step.
   int m_left [N];
   int m_addr [N];
   bit m_gq   [N];
   int m_cyc;
   bit m_sv;
   int m_svoice;
   int m_saddr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void set_div(input int v, input int d);
      div[v*D_W +: D_W] = D_W'(d);
   endfunction

   function automatic void model_step();
      int v, d;
      bit g;
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_left[i] = 0; m_addr[i] = 0; m_gq[i] = 0;
         end
         m_cyc = 0; m_sv = 0; m_svoice = 0; m_saddr = 0;
         return;
      end
      v = m_cyc % N;
      d = int'(div[v*D_W +: D_W]);
      g = gate[v];
      m_sv = 0;
`ifdef POLY_NCO_PHASE_RST_EN
      if (g && !m_gq[v]) begin
         m_addr[v] = 0;
         m_left[v] = d;
      end else
`endif
      if (!g) m_left[v] = d;
      else if (m_left[v] == 0) begin
         m_addr[v] = (m_addr[v] + 1) % (1 << ADDR_W);
         m_left[v] = d;
         m_sv = 1; m_svoice = v; m_saddr = m_addr[v];
      end else m_left[v] = m_left[v] - 1;
      m_gq[v] = g;
      m_cyc++;
   endfunction

   task automatic tick();
      logic [N*ADDR_W-1:0] pk;
      model_step();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) pk[i*ADDR_W +: ADDR_W] = ADDR_W'(m_addr[i]);
      chk("model_step_valid", sv, m_sv);
      chk("model_step_voice", svoice, m_svoice);
      chk("model_step_addr", saddr, m_saddr);
      chk("model_voice_addr", vaddr, pk);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) tick();
      rst = 1'b0;
   endtask

   task automatic wait_step(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!sv && n < 400);
      if (!sv) chk("step_timeout", 0, 1);
   endtask

   typedef struct {
      logic [N-1:0]      gate;
      logic [D_W-1:0]    div_all;
      logic              exp_vld;
      logic [1:0]        exp_voice;
      logic [ADDR_W-1:0] exp_addr;
   } vec_t;

   vec_t vecs [12];

   initial begin
      int n;
      vecs[0]  = '{4'hF, 16'd0, 1'b1, 2'd0, 8'd1};
      vecs[1]  = '{4'hF, 16'd0, 1'b1, 2'd1, 8'd1};
      vecs[2]  = '{4'hF, 16'd0, 1'b1, 2'd2, 8'd1};
      vecs[3]  = '{4'hF, 16'd0, 1'b1, 2'd3, 8'd1};
      vecs[4]  = '{4'hF, 16'd0, 1'b1, 2'd0, 8'd2};
      vecs[5]  = '{4'hF, 16'd0, 1'b1, 2'd1, 8'd2};
      vecs[6]  = '{4'hF, 16'd0, 1'b1, 2'd2, 8'd2};
      vecs[7]  = '{4'hF, 16'd0, 1'b1, 2'd3, 8'd2};
      vecs[8]  = '{4'h0, 16'd0, 1'b0, 2'd3, 8'd2};
      vecs[9]  = '{4'h0, 16'd0, 1'b0, 2'd3, 8'd2};
      vecs[10] = '{4'h0, 16'd0, 1'b0, 2'd3, 8'd2};
      vecs[11] = '{4'h0, 16'd0, 1'b0, 2'd3, 8'd2};

      // Reset state
      do_reset(3);
      chk("rst_step_valid", sv, 0);
      chk("rst_step_voice", svoice, 0);
      chk("rst_step_addr", saddr, 0);
      chk("rst_voice_addr", vaddr, 0);

`ifndef POLY_NCO_PHASE_RST_EN
      // All voices gated, divider 0: one step per cycle in voice order
      for (int k = 0; k < 12; k++) begin
         gate = vecs[k].gate;
         for (int v = 0; v < N; v++) set_div(v, int'(vecs[k].div_all));
         tick();
         chk($sformatf("vec%0d_valid", k), sv, vecs[k].exp_vld);
         chk($sformatf("vec%0d_voice", k), svoice, vecs[k].exp_voice);
         chk($sformatf("vec%0d_addr", k), saddr, vecs[k].exp_addr);
      end
`endif

      // Single voice at divider 3: a step every 16 clocks
      gate = 4'b0010;
      for (int v = 0; v < N; v++) set_div(v, 3);
      do_reset(2);
      wait_step(n);
`ifdef POLY_NCO_PHASE_RST_EN
      chk("v1_first_latency", n, 18);
`else
      chk("v1_first_latency", n, 2);
`endif
      chk("v1_first_voice", svoice, 1);
      chk("v1_first_addr", saddr, 1);
      for (int k = 2; k <= 4; k++) begin
         wait_step(n);
         chk("v1_period", n, 16);
         chk("v1_addr", saddr, k);
         chk("v1_others_idle", {vaddr[31:16], vaddr[7:0]}, 0);
      end

      // Address wrap 0xFF -> 0x00 at divider 2
      gate = 4'b0001;
      div = '0;
      set_div(0, 2);
      do_reset(2);
      n = 0;
      for (int k = 0; k < 300 && !(sv && saddr == 8'hFF); k++) wait_step(n);
      chk("wrap_reached_ff", saddr, 8'hFF);
      wait_step(n);
      chk("wrap_period", n, 12);
      chk("wrap_addr", saddr, 8'h00);
      chk("wrap_voice", svoice, 0);
      chk("wrap_others", vaddr[31:8], 0);

      // Divider change mid-period only affects the following period
      gate = 4'b0100;
      div = '0;
      set_div(2, 10);
      do_reset(2);
      wait_step(n);
      repeat (8) tick();
      set_div(2, 2);
      wait_step(n);
      chk("divchg_current_period", n, 36);
      wait_step(n);
      chk("divchg_next_period", n, 12);
      chk("divchg_voice", svoice, 2);

      // One-cycle reset in the middle of counting
      gate = 4'hF;
      for (int v = 0; v < N; v++) set_div(v, 1);
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_valid", sv, 0);
      chk("midrst_voice", svoice, 0);
      chk("midrst_addr", saddr, 0);
      chk("midrst_vaddr", vaddr, 0);
      tick();
`ifndef POLY_NCO_PHASE_RST_EN
      chk("midrst_slot0_step", {sv, svoice, saddr}, {1'b1, 2'd0, 8'd1});
`endif

      // Note-on after a pause: phase reset vs. resume from held address
      gate = 4'b0001;
      div = '0;
      do_reset(2);
      for (int k = 0; k < 400 && vaddr[7:0] != 8'h40; k++) tick();
      chk("noteon_reached_40", vaddr[7:0], 8'h40);
      gate = 4'b0000;
      set_div(0, 3);
      repeat (8) tick();
      gate = 4'b0001;
`ifdef POLY_NCO_PHASE_RST_EN
      repeat (4) tick();
      chk("noteon_phase_reset", vaddr[7:0], 8'h00);
      wait_step(n);
      chk("noteon_first_addr", saddr, 8'h01);
`else
      wait_step(n);
      chk("noteon_first_addr", saddr, 8'h41);
`endif

      // Random gates, dividers and rare resets against the model
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(0, 7) == 0) gate = N'($urandom);
         if ($urandom_range(0, 15) == 0) set_div(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 5)));
         rst = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
